// File: rtl/switch_fabric_pkg.sv
// Shared constants and source-port mapping for the 5-port registered crossbar.
// Optional build macro SWITCH_FABRIC_CFG_CHECK_EN adds a per-port illegal-config flag.
package switch_fabric_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int NPORT_FIXED = 5;
  localparam int NSRC        = NPORT_FIXED - 1;

  typedef logic [2:0] port_idx_t;

  localparam port_idx_t PORT_A = 3'd0;
  localparam port_idx_t PORT_B = 3'd1;
  localparam port_idx_t PORT_C = 3'd2;
  localparam port_idx_t PORT_D = 3'd3;
  localparam port_idx_t PORT_E = 3'd4;

  // cfg bits walk the other ports alphabetically, skipping the output's own letter
  function automatic port_idx_t src_port(input port_idx_t out_port, input logic [1:0] cfg_bit);
    port_idx_t idx;
    idx = port_idx_t'(cfg_bit);
    if (idx >= out_port) begin
      idx = idx + 3'd1;
    end
    return idx;
  endfunction

endpackage

// File: rtl/sf_out_port.sv
// One crossbar output: 4:1 one-hot mux with illegal-vector suppression, registered; latency 1 cycle.
// No backpressure; samples every cycle. SWITCH_FABRIC_CFG_CHECK_EN adds the registered cfg_err bit.
module sf_out_port
  import switch_fabric_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NSRC-1:0][DATA_W-1:0]  src,
  input  logic [NSRC-1:0]              cfg,
  output logic [DATA_W-1:0]            dout
`ifdef SWITCH_FABRIC_CFG_CHECK_EN
  ,
  output logic                         cfg_err
`endif
);

  logic [DATA_W-1:0] dout_d, dout_q;
  logic [DATA_W-1:0] sel;
  logic              cfg_multi;

  always_comb begin
    sel       = '0;
    cfg_multi = (cfg & (cfg - 4'd1)) != 4'd0;
    for (int b = 0; b < NSRC; b++) begin
      if (cfg[b]) begin
        sel = sel | src[b];
      end
    end
    // more than one select bit: suppress rather than OR the sources together
    dout_d = cfg_multi ? '0 : sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

`ifdef SWITCH_FABRIC_CFG_CHECK_EN
  logic cfg_err_d, cfg_err_q;

  always_comb begin
    cfg_err_d = cfg_multi;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_err = cfg_err_q;
`endif

endmodule

// File: rtl/switch_fabric_5p.sv
// Five-port registered crossbar (A-E), one-hot source select per output, no loopback; latency 1 cycle.
// No handshake or backpressure. SWITCH_FABRIC_CFG_CHECK_EN adds cfg_err[4:0].
module switch_fabric_5p
  import switch_fabric_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NPORT  = NPORT_FIXED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] dinA,
  input  logic [DATA_W-1:0] dinB,
  input  logic [DATA_W-1:0] dinC,
  input  logic [DATA_W-1:0] dinD,
  input  logic [DATA_W-1:0] dinE,
  input  logic [3:0]        sf_cfg_vecA,
  input  logic [3:0]        sf_cfg_vecB,
  input  logic [3:0]        sf_cfg_vecC,
  input  logic [3:0]        sf_cfg_vecD,
  input  logic [3:0]        sf_cfg_vecE,
  output logic [DATA_W-1:0] doutA,
  output logic [DATA_W-1:0] doutB,
  output logic [DATA_W-1:0] doutC,
  output logic [DATA_W-1:0] doutD,
  output logic [DATA_W-1:0] doutE
`ifdef SWITCH_FABRIC_CFG_CHECK_EN
  ,
  output logic [4:0]        cfg_err
`endif
);

  if (NPORT != NPORT_FIXED) begin : g_bad_nport
    $error("switch_fabric_5p: NPORT must be 5");
  end

  logic [DATA_W-1:0] din_all  [NPORT_FIXED];
  logic [3:0]        cfg_all  [NPORT_FIXED];
  logic [DATA_W-1:0] dout_all [NPORT_FIXED];

  assign din_all[PORT_A] = dinA;
  assign din_all[PORT_B] = dinB;
  assign din_all[PORT_C] = dinC;
  assign din_all[PORT_D] = dinD;
  assign din_all[PORT_E] = dinE;

  assign cfg_all[PORT_A] = sf_cfg_vecA;
  assign cfg_all[PORT_B] = sf_cfg_vecB;
  assign cfg_all[PORT_C] = sf_cfg_vecC;
  assign cfg_all[PORT_D] = sf_cfg_vecD;
  assign cfg_all[PORT_E] = sf_cfg_vecE;

  for (genvar o = 0; o < NPORT_FIXED; o++) begin : g_port
    logic [NSRC-1:0][DATA_W-1:0] src;

    for (genvar b = 0; b < NSRC; b++) begin : g_src
      assign src[b] = din_all[src_port(port_idx_t'(o), 2'(b))];
    end

    sf_out_port #(.DATA_W(DATA_W)) u_port (
      .clk     (clk),
      .rst_n   (rst_n),
      .src     (src),
      .cfg     (cfg_all[o]),
      .dout    (dout_all[o])
`ifdef SWITCH_FABRIC_CFG_CHECK_EN
      ,
      .cfg_err (cfg_err[o])
`endif
    );
  end

  assign doutA = dout_all[PORT_A];
  assign doutB = dout_all[PORT_B];
  assign doutC = dout_all[PORT_C];
  assign doutD = dout_all[PORT_D];
  assign doutE = dout_all[PORT_E];

endmodule

// File: tb/tb_switch_fabric_5p.sv
// Randomised and directed checks of switch_fabric_5p against a behavioural crossbar model.
module tb_switch_fabric_5p;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] din  [5];
  logic [3:0]  cfg  [5];
  logic [31:0] dout [5];
`ifdef SWITCH_FABRIC_CFG_CHECK_EN
  logic [4:0]  cfg_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  switch_fabric_5p dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dinA        (din[0]),
    .dinB        (din[1]),
    .dinC        (din[2]),
    .dinD        (din[3]),
    .dinE        (din[4]),
    .sf_cfg_vecA (cfg[0]),
    .sf_cfg_vecB (cfg[1]),
    .sf_cfg_vecC (cfg[2]),
    .sf_cfg_vecD (cfg[3]),
    .sf_cfg_vecE (cfg[4]),
    .doutA       (dout[0]),
    .doutB       (dout[1]),
    .doutC       (dout[2]),
    .doutD       (dout[3]),
    .doutE       (dout[4])
`ifdef SWITCH_FABRIC_CFG_CHECK_EN
    ,
    .cfg_err     (cfg_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: the k-th set bit picks the k-th other port in alphabetical order.
  function automatic logic [31:0] model_out(input int x);
    int k;
    int seen;
    if ($countones(cfg[x]) != 1) return 32'd0;
    k = 0;
    for (int b = 0; b < 4; b++) if (cfg[x][b]) k = b;
    seen = 0;
    for (int p = 0; p < 5; p++) begin
      if (p != x) begin
        if (seen == k) return din[p];
        seen++;
      end
    end
    return 32'd0;
  endfunction

  function automatic logic [4:0] model_err();
    logic [4:0] e;
    for (int p = 0; p < 5; p++) e[p] = ($countones(cfg[p]) > 1);
    return e;
  endfunction

  task automatic check_zero(input string tag);
    for (int p = 0; p < 5; p++) check($sformatf("%s.dout%c", tag, 8'(65 + p)), dout[p], 32'd0);
`ifdef SWITCH_FABRIC_CFG_CHECK_EN
    check($sformatf("%s.cfg_err", tag), 32'(cfg_err), 32'd0);
`endif
  endtask

  // Inputs are stable from 1ns after an edge; expectations come from the inputs at the next edge.
  task automatic clk_check(input string tag);
    logic [31:0] exp [5];
    logic [4:0]  exp_err;
    for (int p = 0; p < 5; p++) exp[p] = model_out(p);
    exp_err = model_err();
    @(posedge clk);
    #1;
    for (int p = 0; p < 5; p++) check($sformatf("%s.dout%c", tag, 8'(65 + p)), dout[p], exp[p]);
`ifdef SWITCH_FABRIC_CFG_CHECK_EN
    check($sformatf("%s.cfg_err", tag), 32'(cfg_err), 32'(exp_err));
`else
    if (exp_err != exp_err) n_fail++;
`endif
  endtask

  task automatic set_base();
    for (int p = 0; p < 5; p++) begin
      din[p] = 32'(p + 1);
      cfg[p] = 4'b0000;
    end
  endtask

  initial begin
    logic [31:0] tbl_a [5];
    logic [31:0] tbl_c [5];
    logic [31:0] tbl_e [5];
    logic [3:0]  sweep [5];
    logic [31:0] prev_b;
    int          r;

    tbl_a = '{32'd2, 32'd3, 32'd4, 32'd5, 32'd0};
    tbl_c = '{32'd1, 32'd2, 32'd4, 32'd5, 32'd0};
    tbl_e = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd0};
    sweep = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};

    rst_n = 1'b0;
    set_base();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // load non-zero outputs so reset clearing is observable
    for (int p = 0; p < 5; p++) cfg[p] = 4'b0001;
    repeat (2) clk_check("preload");
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("rst_async");
    @(posedge clk);
    #1;
    check_zero("rst_hold");
    set_base();
    rst_n = 1'b1;
    #1;
    check_zero("rst_release");
    repeat (2) clk_check("rst_idle");

    // release mid-stream: first capture on the first edge after rst_n rises
    for (int p = 0; p < 5; p++) cfg[p] = 4'b0010;
    #2;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
    check_zero("rst_mid");
    clk_check("rst_first_cap");
    set_base();
    clk_check("idle");

    for (int i = 0; i < 5; i++) begin
      cfg[0] = sweep[i];
      for (int c = 0; c < 3; c++) begin
        clk_check("sweepA");
        check("sweepA.tbl", dout[0], tbl_a[i]);
      end
    end
    set_base();
    for (int i = 0; i < 5; i++) begin
      cfg[2] = sweep[i];
      for (int c = 0; c < 3; c++) begin
        clk_check("sweepC");
        check("sweepC.tbl", dout[2], tbl_c[i]);
      end
    end
    set_base();
    for (int i = 0; i < 5; i++) begin
      cfg[4] = sweep[i];
      for (int c = 0; c < 3; c++) begin
        clk_check("sweepE");
        check("sweepE.tbl", dout[4], tbl_e[i]);
      end
    end

    set_base();
    din[1] = 32'hDEADBEEF;
    cfg[0] = 4'b0001;
    cfg[2] = 4'b0010;
    cfg[3] = 4'b0010;
    cfg[4] = 4'b0010;
    cfg[1] = 4'b0001;
    clk_check("mcast");
    check("mcast.A", dout[0], 32'hDEADBEEF);
    check("mcast.C", dout[2], 32'hDEADBEEF);
    check("mcast.D", dout[3], 32'hDEADBEEF);
    check("mcast.E", dout[4], 32'hDEADBEEF);
    check("mcast.B", dout[1], 32'd1);

    cfg[3] = 4'b0101;
    clk_check("illegal");
    check("illegal.D", dout[3], 32'd0);
`ifdef SWITCH_FABRIC_CFG_CHECK_EN
    check("illegal.err", 32'(cfg_err), 32'h08);
`endif
    cfg[3] = 4'b0100;
    clk_check("restore");
    check("restore.D", dout[3], 32'd3);
`ifdef SWITCH_FABRIC_CFG_CHECK_EN
    check("restore.err", 32'(cfg_err), 32'h00);
`endif

    set_base();
    cfg[0] = 4'b0001;
    din[1] = 32'h0F0F0F0F;
    for (int i = 0; i < 16; i++) begin
      prev_b = din[1];
      clk_check("latency");
      check("latency.A_eq_prevB", dout[0], prev_b);
      din[1] = ~din[1];
    end

    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 5; p++) begin
        din[p] = $urandom;
        r = int'($urandom_range(7, 0));
        if (r == 0)      cfg[p] = 4'b0000;
        else if (r <= 5) cfg[p] = 4'(1 << $urandom_range(3, 0));
        else             cfg[p] = 4'($urandom);
      end
      clk_check("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_fabric_5p.md
Name: switch_fabric_5p

Overview:
- Five-port registered crossbar, one of each port A-E.
- Each output port X forwards exactly one of the other four input ports, chosen by a one-hot 4-bit config vector sf_cfg_vecX. An all-zero vector leaves the port idle.
- Sits between the five processing tiles and routes 32-bit data words among them.
- No loopback path: a port never forwards its own input.

Parameters:
- DATA_W, 32, width of every data input and output.
- NPORT, 5, number of ports. Fixed at 5; any other value is rejected by elaboration check.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- dinA, dinB, dinC, dinD, dinE  input  DATA_W each  input data of ports A-E.
- sf_cfg_vecA, sf_cfg_vecB, sf_cfg_vecC, sf_cfg_vecD, sf_cfg_vecE  input  4 each  one-hot source select for outputs A-E.
- doutA, doutB, doutC, doutD, doutE  output  DATA_W each  registered output data of ports A-E.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset: all dout* are cleared to 0 immediately on rst_n low, independent of clk, and held at 0 while rst_n is low.
- Source mapping: for output X, the bits of sf_cfg_vecX index the other four ports in alphabetical order with X removed. bit0 is the lowest-lettered other port.
  - A: bit0=B, bit1=C, bit2=D, bit3=E.
  - B: bit0=A, bit1=C, bit2=D, bit3=E.
  - C: bit0=A, bit1=B, bit2=D, bit3=E.
  - D: bit0=A, bit1=B, bit2=C, bit3=E.
  - E: bit0=A, bit1=B, bit2=C, bit3=D.
- Next value of doutX:
  - cfg vector 4'b0000: 0 (port idle).
  - exactly one bit set: the selected din.
  - more than one bit set: 0. Illegal config; the data is suppressed, not OR-ed.
- Latency: doutX updates on the rising clk edge after din/cfg is sampled. One cycle latency, no bubbles, full throughput.
- Outputs are independent:
  - any number of outputs may select the same input (multicast);
  - reconfiguring one port never disturbs another.
- No handshake; data is sampled every cycle.
- Reset deasserting mid-stream: the first capture happens on the first rising edge after rst_n goes high.
- Purely synchronous datapath apart from reset; no internal state beyond the output registers (and the error flag, if enabled).

Optional Feature:
- SWITCH_FABRIC_CFG_CHECK_EN defined: adds output cfg_err[4:0].
  - Bit i (0=A … 4=E) is registered together with dout.
  - It is 1 when the corresponding sf_cfg_vec has more than one bit set; otherwise 0.
  - Reset value 0.
- Undefined: no cfg_err port; illegal vectors still produce 0 output silently.

Decomposition:
- Shared package switch_fabric_pkg holds:
  - DATA_W default and NPORT;
  - port index constants PORT_A..PORT_E;
  - a function mapping (output port, cfg bit) to source port index.
- One natural sub-module, sf_out_port, instantiated five times. It contains:
  - a 4:1 one-hot mux with the illegal-vector check;
  - the output register;
  - the cfg_err bit when the feature is enabled.
- The top module only wires the four "other" inputs to each instance in the order above.

Test Plan:
1. Reset: dinA..E=1..5, all cfg=0, rst_n low mid-cycle -> all dout=0 immediately. Release rst_n, hold cfg=0 -> all dout remain 0.
2. Sweep A: dinA..E=1..5, sf_cfg_vecA=0001,0010,0100,1000,0000 each for several cycles -> doutA=2,3,4,5,0, each one cycle after the change; doutB..E stay 0.
3. Sweep C then E, same stimulus:
   - C: doutC=1,2,4,5,0.
   - E: doutE=1,2,3,4,0.
4. Multicast: cfg A=0001 (B), C=0010 (B), D=0010 (B), E=0010 (B), B=0001 (A), dinB=32'hDEADBEEF -> doutA=doutC=doutD=doutE=32'hDEADBEEF and doutB=dinA, after one cycle.
5. Illegal vector: sf_cfg_vecD=0101 -> doutD=0; with SWITCH_FABRIC_CFG_CHECK_EN, cfg_err=5'b01000. Restoring 0100 -> doutD=dinC, cfg_err=0.
6. Latency check: toggle dinB every cycle with sf_cfg_vecA=0001 -> doutA equals dinB delayed exactly one clk.
